polygon_pixel_fifo: RTL and testbench
=====================================

Name: polygon_pixel_fifo

Overview:
- Buffers the per-pixel colour stream produced by the co-processor's colour-comparison stage.
- That stage emits one registered write strobe plus a 9-bit colour per pixel. Colour 510 means "no polygon covers this pixel".
- This block substitutes a programmable background colour for that code and queues the result in a single-clock FIFO. The video-output stage pulls pixels from the FIFO at its own pace.
- It also reports occupancy and a sticky overflow flag so the pipeline controller can detect pixel loss.

Parameters:
- DATA_W, 9, pixel colour width (RGB 3:3:3).
- DEPTH, 16, FIFO entries; must be a power of two, ≥ 4.
- ADDR_W, 4, log2(DEPTH).
- INVISIBLE, 9'd510, colour code that is replaced by the background colour.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- in_wr  input  1  write strobe from the colour-comparison stage; one pixel per high cycle.
- in_polygon_color  input  DATA_W  pixel colour, valid when in_wr=1.
- in_bg_color  input  DATA_W  background colour, sampled on each accepted write.
- in_rd  input  1  read request from the video-output stage.
- in_clr_overflow  input  1  clears the sticky overflow flag.
- out_data  output  DATA_W  registered read data.
- out_valid  output  1  one-cycle pulse; out_data holds a newly popped pixel.
- out_empty  output  1  count == 0.
- out_full  output  1  count == DEPTH.
- out_almost_full  output  1  count ≥ DEPTH-2.
- out_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- out_overflow  output  1  sticky: a write was dropped.

Behaviour:
- **Reset** (reset=0, asynchronous): wr_ptr, rd_ptr and count go to 0. Outputs: out_data=0, out_valid=0, out_overflow=0, out_empty=1, out_full=0, out_almost_full=0. Memory contents are don't-care.
- **Reset mid-operation:** all queued pixels are discarded. After reset deasserts, the first read returns the first post-reset write.
- **Colour substitution** (combinational, before storage): stored = (in_polygon_color == INVISIBLE) ? in_bg_color : in_polygon_color. The comparison is exact over all 9 bits; 511 and every other value pass through unchanged.
- **Read accept:** rd_acc = in_rd & !out_empty. Reads while empty are ignored and produce no out_valid. There is no write-to-read bypass, so an empty FIFO with in_wr=in_rd=1 accepts the write only.
- **Write accept:** wr_acc = in_wr & (!out_full | rd_acc). When full, a simultaneous accepted read frees a slot and the write is accepted; count stays DEPTH.
- **Write drop:** in_wr & out_full & !rd_acc drops the pixel, sets out_overflow, and leaves pointers and count unchanged.
- **Count update:**
  - wr_acc only: +1.
  - rd_acc only: -1.
  - both: unchanged.
- **Pointers:** ADDR_W bits, each increments by 1 per accepted operation and wraps DEPTH-1 → 0.
- **Read latency:** one cycle. On the edge where rd_acc=1, out_data ← mem[rd_ptr] and out_valid ← 1. Otherwise out_valid ← 0 and out_data holds its previous value.
- **Flag timing:** out_empty, out_full, out_almost_full and out_count are decoded from the registered count. They reflect the state after the most recent clock edge.
- **Overflow flag:** sticky; cleared by in_clr_overflow=1 at a clock edge. If a clear and a new drop occur in the same cycle, set wins and out_overflow stays 1.
- **Ordering:** strict FIFO; each accepted pixel is read exactly once.

Test Plan:
- Reset, then write colours 1,2,3 and issue 3 reads → out_data 1,2,3 each one cycle after its read, with out_valid pulses. out_count 3→0 and out_empty=1 at the end.
- Write 510 with in_bg_color=9'd7, then write 511 → reads return 7 then 511.
- Write 16 pixels (0..15) → out_full=1, out_almost_full asserted from count 14, out_count=16. A 17th write without a read → out_overflow=1, count stays 16, and reads return 0..15 in order.
- When full, assert in_wr=in_rd=1 with colour 100 → the read returns the oldest entry, count stays 16, out_overflow stays 0. After draining, 100 is the last pixel out.
- With out_overflow=1, assert in_clr_overflow and a dropped write in the same cycle → out_overflow remains 1. A clear alone on the next cycle → 0.
- Fill with 5 pixels, pulse reset low mid-stream → out_count=0 and out_empty=1 immediately. Then write 42 and read → 42; a read on empty produces no out_valid.

Source files
------------

// File: rtl/polygon_pixel_fifo.sv
// polygon_pixel_fifo
//   Buffers the per-pixel colour stream from the colour-comparison stage.
//   Pixels carrying the INVISIBLE code are replaced by the programmable
//   background colour before storage, then queued in a single-clock FIFO
//   that the video-output stage drains at its own pace. Occupancy flags and
//   a sticky overflow flag let the pipeline controller detect pixel loss.
//
// Ports
//   clk               system clock
//   reset             asynchronous, active-low reset
//   in_wr             write strobe, one pixel per high cycle
//   in_polygon_color  pixel colour, valid with in_wr
//   in_bg_color       background colour, sampled on each accepted write
//   in_rd             read request from the video-output stage
//   in_clr_overflow   clears the sticky overflow flag
//   out_data          registered read data
//   out_valid         one-cycle pulse: out_data holds a newly popped pixel
//   out_empty         count == 0
//   out_full          count == DEPTH
//   out_almost_full   count >= DEPTH-2
//   out_count         current occupancy, 0..DEPTH
//   out_overflow      sticky: a write was dropped
//
// Handshake: the write side has no backpressure. A pixel is accepted when
// in_wr=1 and the FIFO is not full, or when it is full but a read is
// accepted in the same cycle; otherwise it is dropped and out_overflow
// sets. A read is accepted when in_rd=1 and the FIFO is not empty; the
// popped pixel appears on out_data with out_valid=1 one cycle later.
// There is no write-to-read bypass.

module polygon_pixel_fifo #(
  parameter int                DATA_W    = 9,
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] INVISIBLE = 9'd510
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_wr,
  input  logic [DATA_W-1:0] in_polygon_color,
  input  logic [DATA_W-1:0] in_bg_color,
  input  logic              in_rd,
  input  logic              in_clr_overflow,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_empty,
  output logic              out_full,
  output logic              out_almost_full,
  output logic [ADDR_W:0]   out_count,
  output logic              out_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(DEPTH - 2);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic              empty, full;
  logic              rd_acc, wr_acc, wr_drop;
  logic [DATA_W-1:0] wr_color;

  // Flags decode the registered count only, so they describe the state
  // left by the most recent clock edge.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  assign rd_acc  = in_rd & ~empty;
  // A read in the same cycle frees a slot, so a full FIFO still takes it.
  assign wr_acc  = in_wr & (~full | rd_acc);
  assign wr_drop = in_wr & full & ~rd_acc;

  // Exact 9-bit match; every other code, including 511, passes through.
  assign wr_color = (in_polygon_color == INVISIBLE) ? in_bg_color : in_polygon_color;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    if (wr_drop)              ovf_d = 1'b1;
    else if (in_clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers
  // return to zero.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_color;
  end

  assign out_data        = data_q;
  assign out_valid       = valid_q;
  assign out_empty       = empty;
  assign out_full        = full;
  assign out_almost_full = (count_q >= AF_CNT);
  assign out_count       = count_q;
  assign out_overflow    = ovf_q;

endmodule

// File: tb/tb_polygon_pixel_fifo.sv
module tb_polygon_pixel_fifo;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              in_wr = 1'b0;
  logic [DATA_W-1:0] in_polygon_color = '0;
  logic [DATA_W-1:0] in_bg_color = '0;
  logic              in_rd = 1'b0;
  logic              in_clr_overflow = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_empty;
  logic              out_full;
  logic              out_almost_full;
  logic [ADDR_W:0]   out_count;
  logic              out_overflow;

  polygon_pixel_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INVISIBLE(9'd510)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_wr            (in_wr),
    .in_polygon_color (in_polygon_color),
    .in_bg_color      (in_bg_color),
    .in_rd            (in_rd),
    .in_clr_overflow  (in_clr_overflow),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_empty        (out_empty),
    .out_full         (out_full),
    .out_almost_full  (out_almost_full),
    .out_count        (out_count),
    .out_overflow     (out_overflow)
  );

  // ---------------- scoreboard / model ----------------
  logic [DATA_W-1:0] mdl_q[$];   // pixels the FIFO should hold
  logic [DATA_W-1:0] exp_q[$];   // pixels popped, awaiting out_valid
  logic [DATA_W-1:0] mdl_data = '0;
  logic              mdl_ovf  = 1'b0;
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_flags();
    chk("count", 32'(out_count), 32'(mdl_q.size()));
    chk("empty", 32'(out_empty), 32'(mdl_q.size() == 0));
    chk("full",  32'(out_full),  32'(mdl_q.size() == DEPTH));
    chk("afull", 32'(out_almost_full), 32'(mdl_q.size() >= DEPTH - 2));
    chk("ovf",   32'(out_overflow), 32'(mdl_ovf));
    chk("data",  32'(out_data), 32'(mdl_data));
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drives one cycle, predicts, checks.
  task automatic cycle(input logic wr, input logic [DATA_W-1:0] col,
                       input logic [DATA_W-1:0] bg, input logic rd, input logic clr);
    bit ra, wa;
    in_wr = wr; in_polygon_color = col; in_bg_color = bg;
    in_rd = rd; in_clr_overflow = clr;
    ra = rd && (mdl_q.size() > 0);
    wa = wr && ((mdl_q.size() < DEPTH) || ra);
    if (ra) exp_q.push_back(mdl_q.pop_front());
    if (wa) mdl_q.push_back((col == 9'd510) ? bg : col);
    if (wr && !wa)   mdl_ovf = 1'b1;
    else if (clr)    mdl_ovf = 1'b0;
    @(posedge clk);
    #1;
    in_wr = 1'b0; in_rd = 1'b0; in_clr_overflow = 1'b0;
    chk("valid", 32'(out_valid), 32'(ra));
    if (ra && exp_q.size() > 0) mdl_data = exp_q.pop_front();
    chk_flags();
  endtask

  task automatic wr_px(input logic [DATA_W-1:0] col, input logic [DATA_W-1:0] bg);
    cycle(1'b1, col, bg, 1'b0, 1'b0);
  endtask

  task automatic rd_px();
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    mdl_data = '0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk_flags();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // basic order
    wr_px(9'd1, 9'($urandom_range(0, 511)));
    wr_px(9'd2, 9'($urandom_range(0, 511)));
    wr_px(9'd3, 9'($urandom_range(0, 511)));
    repeat (3) rd_px();
    rd_px();  // read on empty: ignored

    // substitution: 510 -> bg, 511 unchanged
    wr_px(9'd510, 9'd7);
    wr_px(9'd511, 9'd300);
    rd_px(); rd_px();

    // fill, overflow, full read+write, clear priority
    for (int i = 0; i < DEPTH; i++) wr_px(9'(i), 9'($urandom_range(0, 511)));
    wr_px(9'd200, 9'd0);                          // dropped
    cycle(1'b0, '0, '0, 1'b0, 1'b1);              // clear alone
    cycle(1'b1, 9'd100, 9'd0, 1'b1, 1'b0);        // full: read + write
    wr_px(9'd201, 9'd0);                          // dropped again
    cycle(1'b1, 9'd202, 9'd0, 1'b0, 1'b1);        // clear + drop: set wins
    cycle(1'b0, '0, '0, 1'b0, 1'b1);              // clear alone
    repeat (DEPTH) rd_px();
    rd_px();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [DATA_W-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? 9'd510 : 9'($urandom_range(0, 511));
      cycle(1'($urandom_range(0, 1)), c, 9'($urandom_range(0, 511)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
    end
    while (mdl_q.size() > 0) rd_px();

    // reset mid-stream
    for (int i = 0; i < 5; i++) wr_px(9'(50 + i), 9'd0);
    reset = 1'b0;
    #2;
    mdl_q.delete(); exp_q.delete();
    mdl_data = '0; mdl_ovf = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk_flags();
    reset = 1'b1;
    @(posedge clk);
    #1;
    wr_px(9'd42, 9'd0);
    rd_px();
    rd_px();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
